pc_seq: RTL and testbench
=========================

# pc_seq

Parametrised program-counter unit for the MIPS core, the successor to the single-width `pc` block. It holds the fetch address and selects the next one each cycle from:
- sequential increment,
- conditional branch,
- absolute jump,
- return via an internal return-address stack (RAS).

It adds stall hold, exception entry with EPC capture, and exception return. It sits at the head of the fetch stage; its `current_pc` drives the instruction memory address.

## Interface
Parameters:
- `ADDR_W`, 32 — PC and address width in bits; must be ≥ 3.
- `RESET_PC`, 0 — PC value loaded on reset.
- `EXC_VEC`, 32'h0000_0080 — exception entry address; truncated to `ADDR_W`.
- `RAS_DEPTH`, 4 — RAS entries; must be ≥ 1.

Ports:
- `clk` in 1 — clock; all state changes on the rising edge.
- `clr_n` in 1 — reset, asynchronous, active-low.
- `stall` in 1 — hold the PC and RAS this cycle.
- `pc_inc_type` in 2 — 00 seq, 01 branch, 10 jump, 11 return.
- `alu_branch_result` in 1 — branch condition; used only when type is 01.
- `link` in 1 — push the return address; honoured with type 10 or 11.
- `abs_addr` in `ADDR_W` — jump target for type 10; fallback target for type 11.
- `branch_addr` in `ADDR_W` — branch target for type 01.
- `exc` in 1 — exception request.
- `eret` in 1 — exception return.
- `current_pc` out `ADDR_W` — registered fetch address.
- `epc` out `ADDR_W` — registered exception PC.
- `ras_count` out `$clog2(RAS_DEPTH+1)` — number of valid RAS entries.
- `ras_miss` out 1 — registered one-cycle pulse: a return was taken with the RAS empty.

## Operation
- `seq` = `current_pc + 4`, modulo 2^`ADDR_W`.
- Every loaded target (branch, jump, return, EPC) has bits [1:0] forced to 0.
- Next-PC priority, highest first:
  1. `exc`: `current_pc` ← `EXC_VEC`; `epc` ← `current_pc`. `exc` overrides `stall`. RAS unchanged.
  2. `eret`: `current_pc` ← `epc`. RAS unchanged. Ignored while `stall`=1.
  3. `stall`: all state holds.
  4. `pc_inc_type` (selection only when `exc`, `eret` and `stall` are all 0):
     - 00: `current_pc` ← `seq`.
     - 01: `current_pc` ← `branch_addr` if `alu_branch_result`=1, else `seq`.
     - 10: `current_pc` ← `abs_addr`. If `link`=1, push `seq`.
     - 11: if `ras_count`>0, `current_pc` ← top of stack and the entry is popped. If `ras_count`=0, `current_pc` ← `abs_addr` and `ras_miss` pulses. If `link`=1, push `seq` after the pop.
- RAS is a circular LIFO with `RAS_DEPTH` entries.
  - Push when full: overwrites the oldest entry; `ras_count` saturates at `RAS_DEPTH`.
  - Pop + push in the same cycle: the top entry is replaced by `seq`. `ras_count` is unchanged if it was >0, and becomes 1 if it was 0.
  - `link` with type 00 or 01 is ignored.
- `exc` and `eret` both high: `exc` wins.
- `ras_miss` is 0 in every cycle except the one following a miss.

## Timing
- All outputs are registered. Decisions use the inputs present before the edge; the result appears after that edge (one-cycle latency).
- No combinational path from any input to any output.
- Reset (`clr_n`=0), immediate and asynchronous:
  - `current_pc`=`RESET_PC`, `epc`=0, `ras_count`=0, `ras_miss`=0; all RAS entries cleared to 0.
  - Reset asserted mid-stall or mid-return discards all pending state.
  - First update occurs on the first rising edge with `clr_n`=1.
- Sequential wrap: `current_pc`=2^`ADDR_W`−4 with type 00 → 0 next cycle.
- Stall held for N cycles: `current_pc` is constant for N cycles, then resumes with the inputs present on release.

## Test plan
- Reset then type 00 for 3 cycles, `RESET_PC`=0 → `current_pc` 0, 4, 8, 0xC; `epc`=0, `ras_count`=0.
- At PC 0x10: type 01 with `alu_branch_result`=1, `branch_addr`=0x103 → 0x100. Then type 01 with result 0 → 0x104.
- At PC 0x20: type 10 with `link`=1, `abs_addr`=0x400 → PC 0x400, `ras_count`=1. Then type 11 → PC 0x24, `ras_count`=0. Another type 11 with `abs_addr`=0x800 → PC 0x800, `ras_miss`=1 for one cycle.
- `RAS_DEPTH`=4: five linked jumps from PCs 0x0, 0x100, 0x200, 0x300, 0x400 → `ras_count`=4. Four returns then yield 0x404, 0x304, 0x204, 0x104. A fifth return gives a miss.
- At PC 0x50: `stall`=1 for 2 cycles with `exc`=1 in the second stall cycle → PC holds at 0x50, then becomes 0x80 with `epc`=0x50. Next, `eret` → PC 0x50.
- Sequential from 0xFFFF_FFFC → 0. Then drive `clr_n` low between edges → PC reads `RESET_PC` immediately, before the next edge.

Source files
------------

// File: rtl/pc_seq.sv
// ============================================================================
// Module  : pc_seq
// Brief   : Program counter with sequential, branch, jump and return-stack
//           targets, stall hold, exception entry and exception return.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_seq #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       EXC_VEC   = 32'h0000_0080,
  parameter int                RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           clr_n,
  input  logic                           stall,
  input  logic [1:0]                     pc_inc_type,
  input  logic                           alu_branch_result,
  input  logic                           link,
  input  logic [ADDR_W-1:0]              abs_addr,
  input  logic [ADDR_W-1:0]              branch_addr,
  input  logic                           exc,
  input  logic                           eret,
  output logic [ADDR_W-1:0]              current_pc,
  output logic [ADDR_W-1:0]              epc,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_miss
);

  localparam int c_cnt_w = $clog2(RAS_DEPTH + 1);
  localparam int c_idx_w = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] c_exc_vec = ADDR_W'(EXC_VEC);
  localparam logic [ADDR_W-1:0] c_align   = {{(ADDR_W-2){1'b1}}, 2'b00};

  localparam logic [1:0] c_type_seq = 2'b00;
  localparam logic [1:0] c_type_br  = 2'b01;
  localparam logic [1:0] c_type_jmp = 2'b10;
  localparam logic [1:0] c_type_ret = 2'b11;

  logic [ADDR_W-1:0]  r_pc, r_epc;
  logic [c_cnt_w-1:0] r_count;
  logic [c_idx_w-1:0] r_top;
  logic               r_miss;
  logic [ADDR_W-1:0]  r_ras [RAS_DEPTH];

  logic [ADDR_W-1:0]  w_seq, w_pc_nxt, w_epc_nxt;
  logic [c_idx_w-1:0] w_top_inc, w_top_dec;
  logic               w_push, w_pop, w_miss;

  assign w_seq     = r_pc + ADDR_W'(4);
  assign w_top_inc = (r_top == c_idx_w'(RAS_DEPTH - 1)) ? '0 : r_top + 1'b1;
  assign w_top_dec = (r_top == '0) ? c_idx_w'(RAS_DEPTH - 1) : r_top - 1'b1;

  always_comb begin
    w_pc_nxt  = r_pc;
    w_epc_nxt = r_epc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_miss    = 1'b0;
    if (exc) begin
      w_pc_nxt  = c_exc_vec;
      w_epc_nxt = r_pc;
    end else if (eret && !stall) begin
      w_pc_nxt = r_epc & c_align;
    end else if (!stall) begin
      case (pc_inc_type)
        c_type_seq: w_pc_nxt = w_seq;
        c_type_br:  w_pc_nxt = alu_branch_result ? (branch_addr & c_align) : w_seq;
        c_type_jmp: begin
          w_pc_nxt = abs_addr & c_align;
          w_push   = link;
        end
        c_type_ret: begin
          if (r_count != '0) begin
            w_pc_nxt = r_ras[r_top] & c_align;
            w_pop    = 1'b1;
          end else begin
            w_pc_nxt = abs_addr & c_align;
            w_miss   = 1'b1;
          end
          w_push = link;
        end
        default: w_pc_nxt = w_seq;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_pc    <= RESET_PC;
      r_epc   <= '0;
      r_miss  <= 1'b0;
      r_count <= '0;
      r_top   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_epc  <= w_epc_nxt;
      r_miss <= w_miss;
      // Pop+push rewrites the top in place; a push into a full stack
      // advances over the oldest slot while the count saturates.
      if (w_pop && w_push) begin
        r_ras[r_top] <= w_seq;
      end else if (w_pop) begin
        r_top   <= w_top_dec;
        r_count <= r_count - 1'b1;
      end else if (w_push) begin
        r_top            <= w_top_inc;
        r_ras[w_top_inc] <= w_seq;
        if (r_count != c_cnt_w'(RAS_DEPTH)) r_count <= r_count + 1'b1;
      end
    end
  end

  assign current_pc = r_pc;
  assign epc        = r_epc;
  assign ras_count  = r_count;
  assign ras_miss   = r_miss;

endmodule

`default_nettype wire

// File: tb/tb_pc_seq.sv
// ============================================================================
// Module  : tb_pc_seq
// Brief   : Directed and random checks of pc_seq against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_seq;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  pc_inc_type = 2'b00;
  logic        alu_branch_result = 1'b0;
  logic        link = 1'b0;
  logic [31:0] abs_addr = '0;
  logic [31:0] branch_addr = '0;
  logic        exc = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] current_pc, epc;
  logic [2:0]  ras_count;
  logic        ras_miss;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: the return stack is a queue whose back is the top.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_epc = 32'h0;
  logic        m_miss = 1'b0;
  logic [31:0] m_ras[$];

  pc_seq #(.ADDR_W(32), .RESET_PC(32'h0), .EXC_VEC(32'h80), .RAS_DEPTH(4)) dut (
    .clk(clk), .clr_n(clr_n), .stall(stall), .pc_inc_type(pc_inc_type),
    .alu_branch_result(alu_branch_result), .link(link), .abs_addr(abs_addr),
    .branch_addr(branch_addr), .exc(exc), .eret(eret), .current_pc(current_pc),
    .epc(epc), .ras_count(ras_count), .ras_miss(ras_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, current_pc, m_pc);
    chk({tag, ".epc"}, epc, m_epc);
    chk({tag, ".cnt"}, {29'd0, ras_count}, m_ras.size());
    chk({tag, ".miss"}, {31'd0, ras_miss}, {31'd0, m_miss});
  endtask

  task automatic m_push(input logic [31:0] v);
    if (m_ras.size() == 4) void'(m_ras.pop_front());
    m_ras.push_back(v);
  endtask

  // Apply one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input string tag, input logic st, input logic [1:0] ty,
                      input logic br, input logic lk, input logic [31:0] ab,
                      input logic [31:0] ba, input logic ex, input logic er);
    logic [31:0] seq, npc, nepc;
    logic        nmiss;
    stall = st; pc_inc_type = ty; alu_branch_result = br; link = lk;
    abs_addr = ab; branch_addr = ba; exc = ex; eret = er;
    seq = m_pc + 32'd4;
    npc = m_pc; nepc = m_epc; nmiss = 1'b0;
    if (ex) begin
      npc = 32'h80; nepc = m_pc;
    end else if (er && !st) begin
      npc = m_epc & ~32'h3;
    end else if (!st) begin
      if (ty == 2'd0) npc = seq;
      else if (ty == 2'd1) npc = br ? (ba & ~32'h3) : seq;
      else if (ty == 2'd2) begin
        npc = ab & ~32'h3;
        if (lk) m_push(seq);
      end else begin
        if (m_ras.size() > 0) npc = m_ras.pop_back() & ~32'h3;
        else begin npc = ab & ~32'h3; nmiss = 1'b1; end
        if (lk) m_push(seq);
      end
    end
    @(posedge clk);
    #1;
    m_pc = npc; m_epc = nepc; m_miss = nmiss;
    chk_all(tag);
  endtask

  initial begin
    #2;
    chk("rst.pc", current_pc, 32'h0);
    chk("rst.epc", epc, 32'h0);
    chk("rst.cnt", {29'd0, ras_count}, 32'h0);
    #10 clr_n = 1'b1;

    step("seq0", 0, 2'd0, 0, 0, 0, 0, 0, 0);
    chk("seq0.lit", current_pc, 32'h4);
    step("seq1", 0, 2'd0, 0, 0, 0, 0, 0, 0);
    step("seq2", 0, 2'd0, 0, 0, 0, 0, 0, 0);
    chk("seq2.lit", current_pc, 32'hC);
    step("seq3", 0, 2'd0, 0, 0, 0, 0, 0, 0);

    step("br_t", 0, 2'd1, 1, 0, 0, 32'h103, 0, 0);
    chk("br_t.lit", current_pc, 32'h100);
    step("br_nt", 0, 2'd1, 0, 0, 0, 32'h999, 0, 0);
    chk("br_nt.lit", current_pc, 32'h104);

    step("j20", 0, 2'd2, 0, 0, 32'h20, 0, 0, 0);
    step("jal", 0, 2'd2, 0, 1, 32'h400, 0, 0, 0);
    chk("jal.cnt.lit", {29'd0, ras_count}, 32'd1);
    step("ret", 0, 2'd3, 0, 0, 32'h777, 0, 0, 0);
    chk("ret.lit", current_pc, 32'h24);
    step("rmiss", 0, 2'd3, 0, 0, 32'h800, 0, 0, 0);
    chk("rmiss.lit", {31'd0, ras_miss}, 32'd1);
    step("after_miss", 0, 2'd0, 0, 0, 0, 0, 0, 0);

    step("j0", 0, 2'd2, 0, 0, 32'h0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) step("jal5", 0, 2'd2, 0, 1, 32'h100 * k, 0, 0, 0);
    chk("full.lit", {29'd0, ras_count}, 32'd4);
    for (int k = 0; k < 4; k++) begin
      step("pop4", 0, 2'd3, 0, 0, 32'h0, 0, 0, 0);
      chk("pop4.lit", current_pc, 32'h404 - 32'h100 * k);
    end
    step("pop5", 0, 2'd3, 0, 0, 32'h600, 0, 0, 0);
    chk("pop5.lit", {31'd0, ras_miss}, 32'd1);

    step("j50", 0, 2'd2, 0, 0, 32'h50, 0, 0, 0);
    step("stall1", 1, 2'd0, 0, 0, 0, 0, 0, 0);
    step("stall_exc", 1, 2'd0, 0, 0, 0, 0, 1, 0);
    chk("exc.lit", epc, 32'h50);
    step("eret", 0, 2'd0, 0, 0, 0, 0, 0, 1);
    chk("eret.lit", current_pc, 32'h50);

    step("jwrap", 0, 2'd2, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
    step("wrap", 0, 2'd0, 0, 0, 0, 0, 0, 0);
    chk("wrap.lit", current_pc, 32'h0);
    step("jal_pre", 0, 2'd2, 0, 1, 32'h300, 0, 0, 0);
    #2 clr_n = 1'b0;
    #1;
    m_pc = 32'h0; m_epc = 32'h0; m_miss = 1'b0; m_ras.delete();
    chk("async_rst.pc", current_pc, 32'h0);
    chk("async_rst.cnt", {29'd0, ras_count}, 32'h0);
    #2 clr_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), $urandom, $urandom,
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
